// File: rtl/nonce_scanner_pkg.sv
// Shared definitions for the nonce scanner and its hasher bench: FSM states,
// header field widths and the byte-order helpers.
package nonce_scanner_pkg;

    localparam int HDR_W      = 640;
    localparam int TEMPLATE_W = 608;
    localparam int NONCE_W    = 32;
    localparam int DIGEST_W   = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [DIGEST_W-1:0] bswap256(input logic [DIGEST_W-1:0] x);
        logic [DIGEST_W-1:0] y;
        for (int i = 0; i < DIGEST_W / 8; i++) begin
            y[i*8 +: 8] = x[(DIGEST_W/8 - 1 - i)*8 +: 8];
        end
        return y;
    endfunction

endpackage

// File: rtl/nonce_scanner_target_compare.sv
// Registered digest-versus-target check: the raw SHA-order digest is byte
// swapped to a big-endian number and compared unsigned against the target.
module target_compare
    import nonce_scanner_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [DIGEST_W-1:0] i_digest,
    input  logic [DIGEST_W-1:0] i_target,
    output logic                o_hit
);

    logic [DIGEST_W-1:0] w_digest_be;
    logic                r_hit;

    assign w_digest_be = bswap256(i_digest);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 1'b0;
        end else if (i_load) begin
            r_hit <= (w_digest_be <= i_target);
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/nonce_scanner.sv
// Sequential nonce scanner feeding a double-SHA-256 hasher one header at a time.
// Define NONCE_SCANNER_ATTEMPTS_EN to add the saturating `attempts` counter.
module nonce_scanner
    import nonce_scanner_pkg::*;
#(
    parameter int NONCE_STEP = 1
`ifdef NONCE_SCANNER_ATTEMPTS_EN
    ,
    parameter int COUNT_W = 48
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TEMPLATE_W-1:0] header_template,
    input  logic [NONCE_W-1:0]    nonce_start,
    input  logic [NONCE_W-1:0]    nonce_end,
    input  logic [DIGEST_W-1:0]   target,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [HDR_W-1:0]      header,
    input  logic                  dig_valid,
    input  logic [DIGEST_W-1:0]   digest,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [NONCE_W-1:0]    found_nonce,
    output logic [DIGEST_W-1:0]   found_hash
`ifdef NONCE_SCANNER_ATTEMPTS_EN
    ,
    output logic [COUNT_W-1:0]    attempts
`endif
);

    state_t                r_state;
    state_t                w_state_next;
    logic [TEMPLATE_W-1:0] r_template;
    logic [NONCE_W-1:0]    r_nonce;
    logic [NONCE_W-1:0]    r_nonce_end;
    logic [NONCE_W-1:0]    w_nonce_inc;
    logic [DIGEST_W-1:0]   r_target;
    logic [DIGEST_W-1:0]   r_digest;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_hdr_valid;
    logic [HDR_W-1:0]      r_header;
    logic                  r_found;
    logic [NONCE_W-1:0]    r_found_nonce;
    logic [DIGEST_W-1:0]   r_found_hash;
    logic                  w_handshake;
    logic                  w_dig_load;
    logic                  w_start_ok;
    logic                  w_range_empty;
    logic                  w_last;
    logic                  w_hit;

    assign w_handshake   = r_hdr_valid && hdr_ready;
    assign w_dig_load    = (r_state == ST_WAIT) && dig_valid;
    assign w_start_ok    = (r_state == ST_IDLE) && start;
    assign w_range_empty = nonce_end < nonce_start;
    // Difference form keeps the last-attempt test free of 32-bit wraparound.
    assign w_last        = (r_nonce_end - r_nonce) < NONCE_W'(NONCE_STEP);
    assign w_nonce_inc   = r_nonce + NONCE_W'(NONCE_STEP);

    target_compare u_target_compare (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_dig_load),
        .i_digest (digest),
        .i_target (r_target),
        .o_hit    (w_hit)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = w_range_empty ? ST_DONE : ST_ISSUE;
            ST_ISSUE: begin
                if (abort)            w_state_next = w_handshake ? ST_DRAIN : ST_IDLE;
                else if (w_handshake) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)          w_state_next = dig_valid ? ST_IDLE : ST_DRAIN;
                else if (dig_valid) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)                w_state_next = ST_IDLE;
                else if (w_hit || w_last) w_state_next = ST_DONE;
                else                      w_state_next = ST_ISSUE;
            end
            ST_DRAIN: if (dig_valid) w_state_next = ST_IDLE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_hdr_valid   <= 1'b0;
            r_header      <= '0;
            r_template    <= '0;
            r_nonce       <= '0;
            r_nonce_end   <= '0;
            r_target      <= '0;
            r_digest      <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next == ST_ISSUE) || (w_state_next == ST_WAIT) ||
                           (w_state_next == ST_CHECK) || (w_state_next == ST_DRAIN);
            r_done      <= (w_state_next == ST_DONE);
            r_hdr_valid <= (w_state_next == ST_ISSUE);
            if (w_start_ok) begin
                r_template    <= header_template;
                r_nonce       <= nonce_start;
                r_nonce_end   <= nonce_end;
                r_target      <= target;
                r_found       <= 1'b0;
                r_found_nonce <= '0;
                r_found_hash  <= '0;
                if (!w_range_empty) begin
                    r_header <= {header_template, bswap32(nonce_start)};
                end
            end
            if (w_dig_load) begin
                r_digest <= digest;
            end
            if ((r_state == ST_CHECK) && !abort) begin
                if (w_hit) begin
                    r_found       <= 1'b1;
                    r_found_nonce <= r_nonce;
                    r_found_hash  <= r_digest;
                end else if (!w_last) begin
                    r_nonce  <= w_nonce_inc;
                    r_header <= {r_template, bswap32(w_nonce_inc)};
                end
            end
        end
    end

`ifdef NONCE_SCANNER_ATTEMPTS_EN
    logic [COUNT_W-1:0] r_attempts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_attempts <= '0;
        end else if (w_start_ok) begin
            r_attempts <= '0;
        end else if (w_handshake && (r_attempts != '1)) begin
            r_attempts <= r_attempts + 1'b1;
        end
    end

    assign attempts = r_attempts;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign hdr_valid   = r_hdr_valid;
    assign header      = r_header;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign found_hash  = r_found_hash;

endmodule

// File: tb/tb_nonce_scanner.sv
// Self-checking bench for nonce_scanner: directed scan table, randomized scans
// against a range-walking reference model, and stall/abort/reset sequences.
module tb_nonce_scanner;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [607:0] header_template;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [639:0] header;
    logic         dig_valid;
    logic [255:0] digest;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
`ifdef NONCE_SCANNER_ATTEMPTS_EN
    logic [47:0]  attempts;
`endif

    nonce_scanner dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .header_template (header_template),
        .nonce_start     (nonce_start),
        .nonce_end       (nonce_end),
        .target          (target),
        .hdr_valid       (hdr_valid),
        .hdr_ready       (hdr_ready),
        .header          (header),
        .dig_valid       (dig_valid),
        .digest          (digest),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .found_nonce     (found_nonce),
        .found_hash      (found_hash)
`ifdef NONCE_SCANNER_ATTEMPTS_EN
        ,
        .attempts        (attempts)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [607:0] tmpl;
    logic [31:0]  issued[$];
    logic         done_seen;
    int           done_cyc;
    int           last_dig_cyc;
    logic         f_found;
    logic [31:0]  f_nonce;
    logic [255:0] f_hash;

    typedef struct {
        logic [31:0]  ns;
        logic [31:0]  ne;
        logic [255:0] tgt;
        int           lat;
        logic         exp_found;
        logic [31:0]  exp_nonce;
        int           exp_count;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Big-endian numeric value the hasher model "produces" for a nonce.
    function automatic logic [255:0] big_val(input logic [31:0] n);
        logic [31:0] x;
        x = (n * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return {x, {7{x ^ n}}};
    endfunction

    // Hasher output is in SHA byte order, i.e. the big-endian value reversed bytewise.
    function automatic logic [255:0] raw_digest(input logic [31:0] n);
        logic [255:0] v;
        logic [255:0] r;
        v = big_val(n);
        r = {<<8{v}};
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic new_template();
        for (int i = 0; i < 19; i++) tmpl[i*32 +: 32] = $urandom;
    endtask

    // Reference: walk the inclusive range, stop at the first value within target.
    task automatic model(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt,
                         output logic ef, output logic [31:0] en, output int ec);
        ef = 1'b0;
        en = '0;
        ec = 0;
        if (ne >= ns) begin
            for (longint unsigned n = ns; n <= ne; n++) begin
                ec++;
                if (big_val(32'(n)) <= tgt) begin
                    ef = 1'b1;
                    en = 32'(n);
                    break;
                end
            end
        end
    endtask

    // Runs one scan with an always-ready hasher of fixed latency.
    task automatic do_scan(input logic [31:0] ns, input logic [31:0] ne,
                           input logic [255:0] tgt, input int lat);
        int          pend;
        logic [31:0] pend_n;
        issued.delete();
        done_seen    = 1'b0;
        done_cyc     = -1;
        last_dig_cyc = -1;
        pend         = -1;
        pend_n       = '0;
        new_template();
        header_template = tmpl;
        nonce_start     = ns;
        nonce_end       = ne;
        target          = tgt;
        start           = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        hdr_ready = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            dig_valid = 1'b0;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                f_found   = found;
                f_nonce   = found_nonce;
                f_hash    = found_hash;
                break;
            end
            if (pend == 0) begin
                dig_valid    = 1'b1;
                digest       = raw_digest(pend_n);
                last_dig_cyc = cyc;
                pend         = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (hdr_valid) begin
                if (issued.size() == 0) chk("start_to_hdr", cyc, 0);
                else                    chk("dig_to_hdr", cyc - last_dig_cyc, 2);
                chk("hdr_tmpl", header[639:32], tmpl);
                pend_n = swap32(header[31:0]);
                issued.push_back(pend_n);
                pend = lat;
            end
            @(negedge clk);
        end
        dig_valid = 1'b0;
        hdr_ready = 1'b0;
        if (done_seen) begin
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("busy_after", busy, 0);
        end
    endtask

    task automatic check_scan(input logic [31:0] ns, input logic ef,
                              input logic [31:0] en, input int ec);
        chk("done_seen", done_seen, 1);
        chk("hdr_count", issued.size(), ec);
        foreach (issued[i]) chk("hdr_nonce", issued[i], 32'(ns + 32'(i)));
        chk("found", f_found, ef);
        chk("found_nonce", f_nonce, ef ? en : 32'd0);
        chk("found_hash", f_hash, ef ? raw_digest(en) : 256'd0);
        if (ec == 0) chk("empty_latency", done_cyc, 0);
        else         chk("dig_to_done", done_cyc - last_dig_cyc, 2);
`ifdef NONCE_SCANNER_ATTEMPTS_EN
        chk("attempts", attempts, issued.size());
`endif
        $display("scan ns=%08h headers=%0d found=%0b nonce=%08h", ns, issued.size(), f_found, f_nonce);
    endtask

    initial begin
        logic         ef;
        logic [31:0]  en;
        int           ec;
        logic [31:0]  ns;
        logic [31:0]  ne;
        logic [255:0] tgt;
        logic [639:0] exp_hdr;

        vecs[0] = '{32'h100, 32'h1FF, '1, 3, 1'b1, 32'h100, 1};
        vecs[1] = '{32'd10, 32'd13, '0, 2, 1'b0, 32'd0, 4};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, '0, 1, 1'b0, 32'd0, 2};
        vecs[3] = '{32'd9, 32'd5, '0, 1, 1'b0, 32'd0, 0};
        vecs[4] = '{32'd7, 32'd7, '1, 0, 1'b1, 32'd7, 1};

        rst = 1'b1; start = 0; abort = 0; hdr_ready = 0; dig_valid = 0;
        digest = '0; header_template = '0; nonce_start = '0; nonce_end = '0; target = '0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_header", header, 0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_found_hash", found_hash, 0);
`ifdef NONCE_SCANNER_ATTEMPTS_EN
        chk("rst_attempts", attempts, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            do_scan(vecs[v].ns, vecs[v].ne, vecs[v].tgt, vecs[v].lat);
            check_scan(vecs[v].ns, vecs[v].exp_found, vecs[v].exp_nonce, vecs[v].exp_count);
        end

        for (int r = 0; r < 20; r++) begin
            ns  = $urandom_range(32'hFFFF_FF00, 0);
            ne  = ns + 32'($urandom_range(7, 0));
            if (r % 5 == 4) ne = ns - 1;
            tgt = rand256();
            tgt[255:224] = $urandom_range(32'h7FFF_FFFF, 0);
            model(ns, ne, tgt, ef, en, ec);
            do_scan(ns, ne, tgt, $urandom_range(4, 0));
            check_scan(ns, ef, en, ec);
        end

        // hdr_ready low for five cycles: the offered header must not move.
        new_template();
        header_template = tmpl; nonce_start = 32'h55; nonce_end = 32'h60; target = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_hdr = {tmpl, swap32(32'h55)};
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", hdr_valid, 1);
            chk("stall_header", header, exp_hdr);
            @(negedge clk);
        end
        chk("stall_valid6", hdr_valid, 1);
        chk("stall_header6", header, exp_hdr);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
        chk("stall_accepted", hdr_valid, 0);
        dig_valid = 1'b1; digest = raw_digest(32'h55);
        @(negedge clk);
        dig_valid = 1'b0;
        @(negedge clk);
        chk("stall_done", done, 1);
        chk("stall_found", found, 1);
        chk("stall_found_nonce", found_nonce, 32'h55);
        $display("stall sequence nonce=55 found=%0b", found);
        @(negedge clk);

        // abort in WAIT: drain the late digest, no done pulse.
        new_template();
        header_template = tmpl; nonce_start = 32'd20; nonce_end = 32'd30; target = '0;
        start = 1'b1; hdr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_hdr_valid", hdr_valid, 1);
        @(negedge clk);
        hdr_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("drain_busy", busy, 1);
            chk("drain_no_done", done, 0);
            chk("drain_no_hdr", hdr_valid, 0);
            @(negedge clk);
        end
        dig_valid = 1'b1; digest = raw_digest(32'd20);
        @(negedge clk);
        dig_valid = 1'b0;
        chk("drain_idle_busy", busy, 0);
        chk("drain_idle_done", done, 0);
        @(negedge clk);
        chk("drain_no_done2", done, 0);
        $display("abort sequence drained busy=%0b", busy);
        do_scan(32'd20, 32'd20, '1, 1);
        check_scan(32'd20, 1'b1, 32'd20, 1);

        // reset in WAIT: outputs clear at once, late digest ignored.
        new_template();
        header_template = tmpl; nonce_start = 32'd100; nonce_end = 32'd200; target = '0;
        start = 1'b1; hdr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        hdr_ready = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hdr_valid", hdr_valid, 0);
        chk("arst_header", header, 0);
        chk("arst_found", found, 0);
        chk("arst_found_nonce", found_nonce, 0);
        chk("arst_found_hash", found_hash, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        dig_valid = 1'b1; digest = raw_digest(32'd100);
        @(negedge clk);
        dig_valid = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_hdr", hdr_valid, 0);
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_found", found, 0);
        $display("reset sequence busy=%0b done=%0b", busy, done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
